// File: rtl/slurm16_pkg.sv
// Shared definitions for the slurm16 core: register file geometry, the
// architectural register roles and the register index type.
package slurm16_pkg;

  localparam int REG_W    = 16;
  localparam int NUM_REGS = 8;
  localparam int PC_IDX   = 7;
  localparam int LR_IDX   = 6;
  localparam int ILR_IDX  = 5;

  typedef logic [2:0]       reg_idx_t;
  typedef logic [REG_W-1:0] word_t;

  // Active-low load strobes of one register, ordered {pipeline, memory, alu}.
  typedef struct packed {
    logic p_b;
    logic m_b;
    logic alu_b;
  } load_strobes_t;

  // True when two or more of the three active-low load strobes are asserted.
  function automatic logic multi_load(input load_strobes_t s);
    return (!s.p_b && !s.m_b) || (!s.p_b && !s.alu_b) || (!s.m_b && !s.alu_b);
  endfunction

endpackage

// File: rtl/reg16_cell.sv
// One 16-bit architectural register: prioritized three-source load
// (pipeline > memory > ALU) followed by increment / decrement / hold.
module reg16_cell
  import slurm16_pkg::*;
#(
  parameter word_t RESET_VAL = '0
) (
  input  logic          CLK,
  input  logic          RSTb,
  input  word_t         alu_in,
  input  word_t         mem_in,
  input  word_t         p_in,
  input  load_strobes_t ld_b,
  input  logic          inc_b,
  input  logic          dec_b,
  output word_t         q
);

  word_t d;

  always_comb begin
    // NOTE: give d a value on every path first so no latch can be inferred.
    d = q;
    if (!ld_b.p_b) begin
      d = p_in;
    end else if (!ld_b.m_b) begin
      d = mem_in;
    end else if (!ld_b.alu_b) begin
      d = alu_in;
    end else if (!inc_b && dec_b) begin
      d = q + word_t'(1);
    end else if (inc_b && !dec_b) begin
      d = q - word_t'(1);
    end
  end

  // NOTE: registers use non-blocking assignments; reset is sampled on the edge.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file16.sv
// Eight-entry register file driven by pipeline16 control vectors: eight
// reg16_cell instances, four combinational read ports and a sticky load-conflict flag.
module register_file16
  import slurm16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic [15:0] aluIn,
  input  logic [15:0] memIn,
  input  logic [15:0] pIn,
  input  logic [7:0]  LD_reg_ALUb,
  input  logic [7:0]  LD_reg_Mb,
  input  logic [7:0]  LD_reg_Pb,
  input  logic [7:0]  INCb,
  input  logic [7:0]  DECb,
  input  logic [2:0]  ALU_A_SEL,
  input  logic [2:0]  ALU_B_SEL,
  input  logic [2:0]  M_SEL,
  input  logic [2:0]  MADDR_SEL,
  input  logic        M_ENb,
  input  logic        ALU_B_from_inP_b,
  output logic [15:0] aluA,
  output logic [15:0] aluB,
  output logic [15:0] memOut,
  output logic [15:0] memAddr,
  output logic        ldConflict
);

  word_t regs [NUM_REGS];
  logic  conflict_now;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    load_strobes_t ld_b;
    assign ld_b = '{p_b: LD_reg_Pb[i], m_b: LD_reg_Mb[i], alu_b: LD_reg_ALUb[i]};

    // Only the PC has a non-zero reset value; all other roles start at zero.
    reg16_cell #(
      .RESET_VAL((i == PC_IDX) ? word_t'(RESET_PC) : '0)
    ) u_cell (
      .CLK    (CLK),
      .RSTb   (RSTb),
      .alu_in (aluIn),
      .mem_in (memIn),
      .p_in   (pIn),
      .ld_b   (ld_b),
      .inc_b  (INCb[i]),
      .dec_b  (DECb[i]),
      .q      (regs[i])
    );
  end

  // Reads see current state only; a write becomes visible after its edge.
  always_comb begin
    aluA    = regs[ALU_A_SEL];
    aluB    = ALU_B_from_inP_b ? regs[ALU_B_SEL] : pIn;
    memOut  = M_ENb ? '0 : regs[M_SEL];
    memAddr = regs[MADDR_SEL];
  end

  always_comb begin
    conflict_now = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (multi_load('{p_b: LD_reg_Pb[i], m_b: LD_reg_Mb[i], alu_b: LD_reg_ALUb[i]})) begin
        conflict_now = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      ldConflict <= 1'b0;
    end else if (conflict_now) begin
      ldConflict <= 1'b1;
    end
  end

endmodule
